// File: rtl/serial_frame_tx_pkg.sv
// Shared definitions for the serial link transmitter and its helpers.
// State encoding, line level and width helper.
package serial_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;

    // Counters never collapse to zero width.
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// Valid/ready word handshake into the serial transmitter.
// Upstream is the master, the transmitter is the slave.
interface serial_frame_tx_if #(
    parameter int DATA_W = 8
);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit period timer: counts CLKS_PER_BIT cycles and strobes bit_end.
// near_end flags the cycle before bit_end so callers can register pulses.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic bit_end,
    output logic near_end
);
    import serial_frame_tx_pkg::*;

    localparam int CW = clog2_min1(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    assign bit_end  = (cnt == LAST);
    assign near_end = (CLKS_PER_BIT > 1) && (cnt == PRE);

    always_ff @(posedge clock) begin
        if (reset || restart || bit_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start, LSB-first data, optional even parity, stop.
// tx_out and tx_done are registered; they carry the value of the state entered.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic               clock,
    input  logic               reset,
    serial_frame_tx_if.slave   link,
    output logic               tx_out,
    output logic               tx_busy,
    output logic               tx_done
);
    import serial_frame_tx_pkg::*;

    localparam int BW = clog2_min1(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic DONE_ON_ENTRY = (CLKS_PER_BIT == 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] sh_nxt;
    logic [BW-1:0]     bit_idx;
    logic              parity;
    logic              bit_end;
    logic              near_end;

    assign sh_nxt        = shreg >> 1;
    assign link.tx_ready = (state == IDLE);
    assign tx_busy       = (state != IDLE);

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clock    (clock),
        .reset    (reset),
        .restart  (state == IDLE),
        .bit_end  (bit_end),
        .near_end (near_end)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            parity  <= 1'b0;
            tx_out  <= LINE_IDLE;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (link.tx_valid) begin
                        state  <= START;
                        shreg  <= link.tx_data;
                        parity <= ^link.tx_data;
                        tx_out <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_out  <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx != LAST_BIT) begin
                            shreg   <= sh_nxt;
                            bit_idx <= bit_idx + 1'b1;
                            tx_out  <= sh_nxt[0];
                        end else if (PARITY_EN == 1) begin
                            state  <= PARITY;
                            tx_out <= parity;
                        end else begin
                            state   <= STOP;
                            tx_out  <= LINE_IDLE;
                            tx_done <= DONE_ON_ENTRY;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state   <= STOP;
                        tx_out  <= LINE_IDLE;
                        tx_done <= DONE_ON_ENTRY;
                    end
                end
                STOP: begin
                    // Line is already high; only the done pulse needs timing.
                    if (bit_end)
                        state <= IDLE;
                    else if (near_end)
                        tx_done <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= LINE_IDLE;
                end
            endcase
        end
    end
endmodule
